nand_init_sequencer: RTL and testbench

- Autonomous bring-up sequencer that drives the host command interface of nand_master (cmd_in/data_in/activate/busy/data_out).
- On a start pulse it runs: controller reset, chip enable, NAND reset, READ ID, five ID-byte fetches, status fetch.
- Captured ID and status are latched for system logic, replacing hand-scripted command sequences.
- Sits between system control logic and nand_master; it is the only driver of nand_master's host port while running.

---
 rtl/nand_init_sequencer_if.sv | 25 ++
 rtl/nand_init_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_nand_init_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nand_init_sequencer_if.sv
// Host-port bundle between the bring-up sequencer and nand_master.
// master: the side issuing commands (the sequencer); slave: nand_master.
interface nand_init_sequencer_if;
    logic [5:0] nm_cmd_in;
    logic [7:0] nm_data_in;
    logic       nm_activate;
    logic       nm_busy;
    logic [7:0] nm_data_out;

    modport master (
        output nm_cmd_in,
        output nm_data_in,
        output nm_activate,
        input  nm_busy,
        input  nm_data_out
    );

    modport slave (
        input  nm_cmd_in,
        input  nm_data_in,
        input  nm_activate,
        output nm_busy,
        output nm_data_out
    );
endinterface

// File: rtl/nand_init_sequencer.sv
// nand_init_sequencer: autonomous NAND bring-up sequence for nand_master.
// On an accepted start it issues controller reset, chip enable, NAND reset,
// READ ID, five ID-byte fetches and a status fetch, latching ID and status.
// Optional build macro NAND_INIT_SEQ_ID_CHECK_EN: compare ID byte 0 against
// EXPECT_MFR and abort with err_code 2 on mismatch.
module nand_init_sequencer #(
    parameter logic [5:0] CMD_RESET       = 6'h01,
    parameter logic [5:0] CMD_CHIP_ENABLE = 6'h0E,
    parameter logic [5:0] CMD_NAND_RESET  = 6'h04,
    parameter logic [5:0] CMD_READ_ID     = 6'h06,
    parameter logic [5:0] CMD_GET_ID_BYTE = 6'h13,
    parameter logic [5:0] CMD_GET_STATUS  = 6'h0D,
    parameter int         SETTLE_CYCLES   = 2,
    parameter int         TIMEOUT_CYCLES  = 65535
`ifdef NAND_INIT_SEQ_ID_CHECK_EN
    ,
    parameter logic [7:0] EXPECT_MFR      = 8'h2C
`endif
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [7:0]  ce_sel,
    output logic        seq_busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [3:0]  failed_step,
    output logic [39:0] id_bytes,
    output logic [7:0]  status,
    nand_init_sequencer_if.master nm
);

    // Step indices of the bring-up sequence.
    localparam logic [3:0] STEP_RESET     = 4'd0;
    localparam logic [3:0] STEP_CE        = 4'd1;
    localparam logic [3:0] STEP_NAND_RST  = 4'd2;
    localparam logic [3:0] STEP_READ_ID   = 4'd3;
    localparam logic [3:0] STEP_ID_FIRST  = 4'd4;
    localparam logic [3:0] STEP_ID_LAST   = 4'd8;
    localparam logic [3:0] STEP_STATUS    = 4'd9;

    // Settle counter is sized for at least one bit so a zero/one setting still elaborates.
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        (SETTLE_CYCLES > 0) ? SETTLE_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
`ifdef NAND_INIT_SEQ_ID_CHECK_EN
    localparam logic [1:0] ERR_ID_MISMATCH = 2'd2;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_SETTLE  = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t              state_q,       state_d;
    logic [3:0]          step_q,        step_d;
    logic [15:0]         tmo_q,         tmo_d;
    logic [SETTLE_W-1:0] settle_q,      settle_d;
    logic [5:0]          cmd_q,         cmd_d;
    logic [7:0]          data_q,        data_d;
    logic [7:0]          ce_q,          ce_d;
    logic [39:0]         id_q,          id_d;
    logic [7:0]          status_q,      status_d;
    logic [1:0]          err_code_q,    err_code_d;
    logic [3:0]          failed_step_q, failed_step_d;

    // Byte lane of id_bytes written by the current ID-fetch step.
    logic [2:0] id_idx;
    assign id_idx = 3'(step_q - STEP_ID_FIRST);

    // Command code issued for a given step.
    function automatic logic [5:0] step_cmd(input logic [3:0] s);
        logic [5:0] c;
        case (s)
            STEP_RESET:    c = CMD_RESET;
            STEP_CE:       c = CMD_CHIP_ENABLE;
            STEP_NAND_RST: c = CMD_NAND_RESET;
            STEP_READ_ID:  c = CMD_READ_ID;
            STEP_STATUS:   c = CMD_GET_STATUS;
            default:       c = CMD_GET_ID_BYTE;
        endcase
        return c;
    endfunction

    // Data byte accompanying a step: CE index for chip enable, zero otherwise
    // (READ ID uses address 00).
    function automatic logic [7:0] step_data(input logic [3:0] s, input logic [7:0] ce);
        return (s == STEP_CE) ? ce : 8'h00;
    endfunction

    // State and datapath registers; everything returns to zero on reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= S_IDLE;
            step_q        <= '0;
            tmo_q         <= '0;
            settle_q      <= '0;
            cmd_q         <= '0;
            data_q        <= '0;
            ce_q          <= '0;
            id_q          <= '0;
            status_q      <= '0;
            err_code_q    <= ERR_NONE;
            failed_step_q <= '0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            tmo_q         <= tmo_d;
            settle_q      <= settle_d;
            cmd_q         <= cmd_d;
            data_q        <= data_d;
            ce_q          <= ce_d;
            id_q          <= id_d;
            status_q      <= status_d;
            err_code_q    <= err_code_d;
            failed_step_q <= failed_step_d;
        end
    end

    // Next-state logic: step sequencing, settle/timeout counting and captures.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        tmo_d         = tmo_q;
        settle_d      = settle_q;
        cmd_d         = cmd_q;
        data_d        = data_q;
        ce_d          = ce_q;
        id_d          = id_q;
        status_d      = status_q;
        err_code_d    = err_code_q;
        failed_step_d = failed_step_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_code_d    = ERR_NONE;
                    failed_step_d = '0;
                    step_d        = STEP_RESET;
                    ce_d          = ce_sel;
                    cmd_d         = step_cmd(STEP_RESET);
                    data_d        = step_data(STEP_RESET, ce_sel);
                    tmo_d         = '0;
                    state_d       = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Command/data were loaded on entry and stay put until CAPTURE.
                settle_d = '0;
                state_d  = (SETTLE_CYCLES > 0) ? S_SETTLE : S_WAIT;
            end

            S_SETTLE: begin
                // Give nand_master time to raise busy before it is trusted.
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_WAIT;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            S_WAIT: begin
                if (!nm.nm_busy) begin
                    state_d = S_CAPTURE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d         = '0;
                    err_code_d    = ERR_TIMEOUT;
                    failed_step_d = step_q;
                    state_d       = S_ERR;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            S_CAPTURE: begin
                tmo_d = '0;
                if (step_q >= STEP_ID_FIRST && step_q <= STEP_ID_LAST) begin
                    id_d[{id_idx, 3'b000} +: 8] = nm.nm_data_out;
                end
                if (step_q == STEP_STATUS) begin
                    status_d = nm.nm_data_out;
                    state_d  = S_DONE;
                end else begin
                    step_d  = step_q + 4'd1;
                    cmd_d   = step_cmd(step_q + 4'd1);
                    data_d  = step_data(step_q + 4'd1, ce_q);
                    state_d = S_ISSUE;
                end
`ifdef NAND_INIT_SEQ_ID_CHECK_EN
                // Wrong manufacturer: keep the captured byte, stop issuing commands.
                if (step_q == STEP_ID_FIRST && nm.nm_data_out != EXPECT_MFR) begin
                    step_d        = step_q;
                    cmd_d         = cmd_q;
                    data_d        = data_q;
                    err_code_d    = ERR_ID_MISMATCH;
                    failed_step_d = STEP_ID_FIRST;
                    state_d       = S_ERR;
                end
`endif
            end

            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign nm.nm_cmd_in   = cmd_q;
    assign nm.nm_data_in  = data_q;
    assign nm.nm_activate = (state_q == S_ISSUE);

    assign seq_busy    = (state_q == S_ISSUE) || (state_q == S_SETTLE) ||
                         (state_q == S_WAIT)  || (state_q == S_CAPTURE);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERR);
    assign err_code    = err_code_q;
    assign failed_step = failed_step_q;
    assign id_bytes    = id_q;
    assign status      = status_q;

endmodule

// File: tb/tb_nand_init_sequencer.sv
// Directed bench for nand_init_sequencer with a small nand_master responder:
// busy for 5 cycles per command, ID 2C E5 FF 03 86, status E0.
`define CHK(tag, obs, exp) \
    begin \
        vectors++; \
        assert ((obs) === (exp)) else begin \
            miscompares++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

module tb_nand_init_sequencer;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ce_sel = 8'h00;
    logic        seq_busy, done, error;
    logic [1:0]  err_code;
    logic [3:0]  failed_step;
    logic [39:0] id_bytes;
    logic [7:0]  status;

    nand_init_sequencer_if nif ();

    nand_init_sequencer #(.TIMEOUT_CYCLES(100)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .start       (start),
        .ce_sel      (ce_sel),
        .seq_busy    (seq_busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .failed_step (failed_step),
        .id_bytes    (id_bytes),
        .status      (status),
        .nm          (nif)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Responder state.
    logic [7:0] idv [5];
    bit         hold_en = 1'b0;
    logic       hold_q;
    logic [2:0] bcnt;
    int         idx;
    logic       in_step;
    logic [5:0] cur_cmd;
    logic [7:0] cur_dat;
    int         unstable = 0;

    // Event log.
    int         cyc = 0;
    int         act_cnt = 0;
    int         act_cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         err_cyc = 0;
    logic [5:0] cmd_log [64];
    logic [7:0] dat_log [64];

    assign nif.nm_busy = (bcnt != 3'd0) || hold_q;

    // nand_master behaviour: busy after each activate, data for fetch commands.
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bcnt            <= 3'd0;
            hold_q          <= 1'b0;
            idx             <= 0;
            in_step         <= 1'b0;
            cur_cmd         <= 6'h00;
            cur_dat         <= 8'h00;
            nif.nm_data_out <= 8'h00;
        end else begin
            if (!hold_en) hold_q <= 1'b0;
            if (bcnt != 3'd0) bcnt <= bcnt - 3'd1;
            if (in_step && (nif.nm_cmd_in !== cur_cmd || nif.nm_data_in !== cur_dat))
                unstable <= unstable + 1;
            if (in_step && !nif.nm_busy) in_step <= 1'b0;
            if (nif.nm_activate) begin
                bcnt    <= 3'd5;
                in_step <= 1'b1;
                cur_cmd <= nif.nm_cmd_in;
                cur_dat <= nif.nm_data_in;
                if (nif.nm_cmd_in == 6'h04 && hold_en) hold_q <= 1'b1;
                if (nif.nm_cmd_in == 6'h06) idx <= 0;
                if (nif.nm_cmd_in == 6'h13) begin
                    nif.nm_data_out <= (idx < 5) ? idv[idx] : 8'hXX;
                    idx <= idx + 1;
                end
                if (nif.nm_cmd_in == 6'h0D) nif.nm_data_out <= 8'hE0;
            end
        end
    end

    // Running counts of activates, done and error pulses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (nif.nm_activate === 1'b1) begin
            cmd_log[act_cnt % 64] <= nif.nm_cmd_in;
            dat_log[act_cnt % 64] <= nif.nm_data_in;
            act_cnt <= act_cnt + 1;
            act_cyc <= cyc;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (error === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    task automatic pulse_start(input logic [7:0] ce);
        @(negedge clk);
        start  = 1'b1;
        ce_sel = ce;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_evt(input int maxc, input int d0, input int e0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done_cnt != d0 || err_cnt != e0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_act(input int maxc, input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (act_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic [5:0] exp_cmd [10];
    int a0, d0, e0, u0;
    bit ok;

    initial begin
        idv[0] = 8'h2C; idv[1] = 8'hE5; idv[2] = 8'hFF; idv[3] = 8'h03; idv[4] = 8'h86;
        exp_cmd[0] = 6'h01; exp_cmd[1] = 6'h0E; exp_cmd[2] = 6'h04; exp_cmd[3] = 6'h06;
        for (int i = 4; i < 9; i++) exp_cmd[i] = 6'h13;
        exp_cmd[9] = 6'h0D;

        // Reset values.
        repeat (3) @(negedge clk);
        `CHK("rst_seq_busy", seq_busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_error", error, 1'b0)
        `CHK("rst_err_code", err_code, 2'd0)
        `CHK("rst_failed_step", failed_step, 4'd0)
        `CHK("rst_id_bytes", id_bytes, 40'h0)
        `CHK("rst_status", status, 8'h00)
        `CHK("rst_activate", nif.nm_activate, 1'b0)
        `CHK("rst_cmd", nif.nm_cmd_in, 6'h00)
        `CHK("rst_data", nif.nm_data_in, 8'h00)
        nreset = 1'b1;
        repeat (5) @(negedge clk);
        `CHK("idle_no_activate", act_cnt, 0)

        // Full sequence, ce_sel 00.
        a0 = act_cnt; d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'h00);
        `CHK("run1_busy_high", seq_busy, 1'b1)
        wait_evt(500, d0, e0, ok);
        `CHK("run1_finished", ok, 1'b1)
        `CHK("run1_done_cnt", done_cnt - d0, 1)
        `CHK("run1_err_cnt", err_cnt - e0, 0)
        `CHK("run1_activates", act_cnt - a0, 10)
        for (int i = 0; i < 10; i++) `CHK("run1_cmd_order", cmd_log[(a0 + i) % 64], exp_cmd[i])
        `CHK("run1_ce_data", dat_log[(a0 + 1) % 64], 8'h00)
        `CHK("run1_readid_addr", dat_log[(a0 + 3) % 64], 8'h00)
        `CHK("run1_id_bytes", id_bytes, 40'h8603FFE52C)
        `CHK("run1_status", status, 8'hE0)
        `CHK("run1_err_code", err_code, 2'd0)
        `CHK("run1_busy_low", seq_busy, 1'b0)
        repeat (10) @(negedge clk);
        `CHK("run1_single_done", done_cnt - d0, 1)
        `CHK("run1_no_more_act", act_cnt - a0, 10)

        // ce_sel 03: chip-enable data and stability of the command bus.
        a0 = act_cnt; d0 = done_cnt; e0 = err_cnt; u0 = unstable;
        pulse_start(8'h03);
        wait_evt(500, d0, e0, ok);
        `CHK("ce3_finished", ok, 1'b1)
        `CHK("ce3_cmd", cmd_log[(a0 + 1) % 64], 6'h0E)
        `CHK("ce3_data", dat_log[(a0 + 1) % 64], 8'h03)
        `CHK("ce3_stable", unstable - u0, 0)
        `CHK("ce3_done", done_cnt - d0, 1)

        // Start during step 5 is ignored.
        a0 = act_cnt; d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'h00);
        wait_act(500, a0 + 6, ok);
        `CHK("restart_reach_step5", ok, 1'b1)
        pulse_start(8'h00);
        wait_evt(500, d0, e0, ok);
        `CHK("restart_finished", ok, 1'b1)
        repeat (20) @(negedge clk);
        `CHK("restart_activates", act_cnt - a0, 10)
        `CHK("restart_done", done_cnt - d0, 1)
        `CHK("restart_err", err_cnt - e0, 0)

        // nreset during step 6, then a clean run.
        a0 = act_cnt; d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'h00);
        wait_act(500, a0 + 7, ok);
        `CHK("mrst_reach_step6", ok, 1'b1)
        repeat (2) @(negedge clk);
        nreset = 1'b0;
        #1;
        `CHK("mrst_seq_busy", seq_busy, 1'b0)
        `CHK("mrst_activate", nif.nm_activate, 1'b0)
        `CHK("mrst_id_bytes", id_bytes, 40'h0)
        `CHK("mrst_status", status, 8'h00)
        `CHK("mrst_err_code", err_code, 2'd0)
        `CHK("mrst_cmd", nif.nm_cmd_in, 6'h00)
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (5) @(negedge clk);
        `CHK("mrst_no_done", done_cnt - d0, 0)
        `CHK("mrst_no_error", err_cnt - e0, 0)
        `CHK("mrst_act_frozen", act_cnt - a0, 7)
        a0 = act_cnt;
        pulse_start(8'h00);
        wait_evt(500, d0, e0, ok);
        `CHK("mrst_rerun_finished", ok, 1'b1)
        `CHK("mrst_rerun_activates", act_cnt - a0, 10)
        `CHK("mrst_rerun_done", done_cnt - d0, 1)
        `CHK("mrst_rerun_id", id_bytes, 40'h8603FFE52C)
        `CHK("mrst_rerun_status", status, 8'hE0)

        // Busy stuck after NAND_RESET: timeout abort at step 2.
        hold_en = 1'b1;
        a0 = act_cnt; d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'h00);
        wait_evt(500, d0, e0, ok);
        `CHK("tmo_finished", ok, 1'b1)
        `CHK("tmo_err_cnt", err_cnt - e0, 1)
        `CHK("tmo_done_cnt", done_cnt - d0, 0)
        `CHK("tmo_err_code", err_code, 2'd1)
        `CHK("tmo_failed_step", failed_step, 4'd2)
        `CHK("tmo_latency", err_cyc - act_cyc, 103)
        repeat (20) @(negedge clk);
        `CHK("tmo_activates", act_cnt - a0, 3)
        `CHK("tmo_busy_low", seq_busy, 1'b0)
        `CHK("tmo_code_held", err_code, 2'd1)
        `CHK("tmo_id_kept", id_bytes, 40'h8603FFE52C)
        hold_en = 1'b0;
        repeat (2) @(negedge clk);

        // Next start clears the error fields.
        d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'h00);
        `CHK("clr_err_code", err_code, 2'd0)
        `CHK("clr_failed_step", failed_step, 4'd0)
        wait_evt(500, d0, e0, ok);
        `CHK("clr_done", done_cnt - d0, 1)

`ifdef NAND_INIT_SEQ_ID_CHECK_EN
        // Wrong manufacturer byte aborts after the first ID fetch.
        idv[0] = 8'h98;
        a0 = act_cnt; d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'h00);
        wait_evt(500, d0, e0, ok);
        `CHK("idchk_finished", ok, 1'b1)
        `CHK("idchk_err_cnt", err_cnt - e0, 1)
        `CHK("idchk_err_code", err_code, 2'd2)
        `CHK("idchk_failed_step", failed_step, 4'd4)
        `CHK("idchk_byte0", id_bytes[7:0], 8'h98)
        `CHK("idchk_upper_kept", id_bytes[39:8], 32'h8603FFE5)
        repeat (20) @(negedge clk);
        `CHK("idchk_activates", act_cnt - a0, 5)
        idv[0] = 8'h2C;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`undef CHK
